uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameters SHALL be:
  CLK_FREQ  50_000_000  clock frequency in Hz
  BAUD      115200      bit rate in bits per second
REQ-002 Derived constants SHALL be CLKS_PER_BIT = CLK_FREQ/BAUD (integer division) and HALF = CLKS_PER_BIT/2.
REQ-003 Ports SHALL be:
  clk        input   1  system clock, rising edge
  rst        input   1  reset, asynchronous, active-high
  rx         input   1  serial line, asynchronous to clk, idle high
  data       output  8  received byte
  valid      output  1  data holds an unconsumed byte
  ready      input   1  consumer accepts data when valid && ready
  frame_err  output  1  one-cycle pulse: stop bit sampled low
  overrun    output  1  one-cycle pulse: byte dropped, previous byte unconsumed
REQ-004 The block SHALL use one clock (clk); reset SHALL be asynchronous and active-high (rst).

Function
REQ-005 rx SHALL pass through a 2-flop synchronizer (rx_s) before any use; the synchronizer resets to 1.
REQ-006 Frame format SHALL be 8N1, LSB first: start 0, 8 data bits, stop 1.
REQ-007 States SHALL be IDLE, START, DATA, STOP and WAIT_HIGH; a bit counter ctr and a 3-bit index bit_idx SHALL be used.
REQ-008 IDLE: when rx_s==0, go to START with ctr=0.
REQ-009 START: when ctr==HALF-1, sample rx_s; if 0, go to DATA with ctr=0 and bit_idx=0; if 1 (false start), go to IDLE with no output; otherwise ctr++.
REQ-010 DATA: when ctr==CLKS_PER_BIT-1, sample rx_s into the shift register (shift right, insert at bit 7), reset ctr, and increment bit_idx; after bit_idx 7 is sampled, go to STOP; otherwise ctr++.
REQ-011 STOP: when ctr==CLKS_PER_BIT-1, sample rx_s; if 1, deliver the byte per REQ-013 and go to IDLE; if 0, pulse frame_err, discard the byte, and go to WAIT_HIGH.
REQ-012 WAIT_HIGH: stay until rx_s==1, then go to IDLE; no frame SHALL start while in this state.
REQ-013 Delivery: if valid==0, or valid&&ready in the same cycle, load data and set valid=1; otherwise pulse overrun, keep the old data, and keep valid=1.
REQ-014 When valid&&ready and no delivery occurs in that cycle, valid SHALL clear on the next edge; data SHALL be held stable while valid==1.
REQ-015 Latency: with the first clk edge that samples rx low counted as edge 0, valid SHALL be high after edge 2+HALF+9*CLKS_PER_BIT.
REQ-016 frame_err and overrun SHALL each be high for exactly one cycle per event and SHALL never be asserted together.
REQ-017 Reception SHALL continue regardless of ready; back-to-back frames with a 1-bit stop SHALL be received without loss.

Reset
REQ-018 While rst is high: state=IDLE, ctr=0, bit_idx=0, shift register=0, data=0x00, valid=0, frame_err=0, overrun=0, synchronizer=1.
REQ-019 Asserting rst mid-frame SHALL abort the frame with no valid, frame_err or overrun; the first full frame after release SHALL be received correctly.

Verification (CLK_FREQ=1_600_000, BAUD=100_000: CLKS_PER_BIT=16, HALF=8)
REQ-020 Send 0x55 with ready=1 -> valid high for exactly 1 cycle after edge 154; data=0x55; no error pulses.
REQ-021 Drive rx low for 4 cycles, then high -> no valid, frame_err or overrun; a following 0xC3 frame is received as 0xC3.
REQ-022 Send 0xA3 with stop bit 0, then hold rx low for 3 bit times -> one frame_err pulse, valid stays 0, no frame starts until rx returns high; a next 0x3C frame is received as 0x3C.
REQ-023 Send 0x12 then 0x34 back-to-back with ready=0 -> data=0x12 and valid=1 held; one overrun pulse at the end of 0x34; set ready=1 -> valid clears next cycle.
REQ-024 Keep ready=1 and send 0x00, 0xFF, 0x81 back-to-back -> three valid pulses with data 0x00, 0xFF, 0x81 in order; no errors.
REQ-025 Pulse rst during bit 4 of a frame -> outputs take their reset values; the next 0xF0 frame is received as 0xF0.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchronizer, mid-bit sampling and a
// one-deep valid/ready output holding register with overrun and framing-error pulses.
module uart_rx #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned HALF         = CLKS_PER_BIT / 2;
  localparam int unsigned CtrW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CtrW-1:0] CtrHalfLast = CtrW'(HALF - 1);
  localparam logic [CtrW-1:0] CtrBitLast  = CtrW'(CLKS_PER_BIT - 1);
  localparam logic [CtrW-1:0] CtrOne      = CtrW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        sync_q, sync_d;
  logic [CtrW-1:0]   ctr_q, ctr_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        data_q, data_d;
  logic              valid_q, valid_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              rx_s;

  assign rx_s = sync_q[1];

  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[0], rx};
    ctr_d       = ctr_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    // Consumption; a delivery in the same cycle below re-asserts valid.
    if (valid_q && ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d = StStart;
          ctr_d   = '0;
        end
      end

      StStart: begin
        if (ctr_q == CtrHalfLast) begin
          if (!rx_s) begin
            state_d   = StData;
            ctr_d     = '0;
            bit_idx_d = '0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          ctr_d = ctr_q + CtrOne;
        end
      end

      StData: begin
        if (ctr_q == CtrBitLast) begin
          shift_d   = {rx_s, shift_q[7:1]};
          ctr_d     = '0;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end
        end else begin
          ctr_d = ctr_q + CtrOne;
        end
      end

      StStop: begin
        if (ctr_q == CtrBitLast) begin
          ctr_d = '0;
          if (rx_s) begin
            state_d = StIdle;
            if (!valid_q || ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            shift_d     = '0;
            state_d     = StWaitHigh;
          end
        end else begin
          ctr_d = ctr_q + CtrOne;
        end
      end

      StWaitHigh: begin
        // A line stuck low after a bad stop bit must not be taken as a new start bit.
        if (rx_s) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      sync_q      <= 2'b11;
      ctr_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      ctr_q       <= ctr_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized bench for uart_rx at 16 clocks per bit; a negedge monitor
// records handshakes and pulses, expectations come from frame-level bookkeeping.
module tb_uart_rx;

  localparam int unsigned ClkFreq = 1_600_000;
  localparam int unsigned Baud    = 100_000;
  localparam int          Cpb     = 16;
  localparam int          Half    = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;

  uart_rx #(
    .CLK_FREQ(ClkFreq),
    .BAUD    (Baud)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .ready    (ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] acc_q[$];
  logic [7:0] exp_q[$];
  int vrise = 0, rise_cyc = -1, vwidth = 0, last_width = 0;
  int fe_cnt = 0, ov_cnt = 0, fe_wide = 0, ov_wide = 0, both_cnt = 0, stab_err = 0;
  logic valid_p = 1'b0, fe_p = 1'b0, ov_p = 1'b0, acc_p = 1'b0;
  logic [7:0] data_p = 8'h00;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Observation only: samples just after each negedge, once drivers have settled.
  initial forever begin
    @(negedge clk);
    #1;
    if (!rst) begin
      if (valid && ready) acc_q.push_back(data);
      if (valid && !valid_p) begin
        vrise++;
        rise_cyc = cyc;
        vwidth   = 1;
      end else if (valid) begin
        vwidth++;
      end else if (valid_p) begin
        last_width = vwidth;
      end
      if (valid_p && !acc_p && valid && (data !== data_p)) stab_err++;
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (frame_err && fe_p) fe_wide++;
      if (overrun && ov_p) ov_wide++;
      if (frame_err && overrun) both_cnt++;
    end
    valid_p = valid;
    acc_p   = valid && ready;
    data_p  = data;
    fe_p    = frame_err;
    ov_p    = overrun;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; e0 is the cycle number of the first edge that samples the start bit.
  task automatic send_frame(input logic [7:0] b, input logic stop, output int e0);
    e0 = cyc + 1;
    rx = 1'b0;
    wait_cycles(Cpb);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cycles(Cpb);
    end
    rx = stop;
    wait_cycles(Cpb);
  endtask

  initial begin
    int e0;
    int n;
    int s_vrise, s_fe, s_ov, s_acc;
    logic [7:0] b;
    logic [7:0] first;
    logic [7:0] b24[3];

    rst   = 1'b1;
    rx    = 1'b1;
    ready = 1'b1;
    wait_cycles(3);
    #2;
    check("reset_data", 32'(data), 32'h00);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    wait_cycles(20);

    // Single frame latency and pulse width.
    s_vrise = vrise;
    send_frame(8'h55, 1'b1, e0);
    exp_q.push_back(8'h55);
    rx = 1'b1;
    wait_cycles(4);
    check("b55_rise_cycle", 32'(rise_cyc), 32'(e0 + 2 + Half + 9 * Cpb));
    check("b55_valid_width", 32'(last_width), 32'd1);
    check("b55_data", 32'(acc_q[acc_q.size() - 1]), 32'h55);
    check("b55_one_valid", 32'(vrise - s_vrise), 32'd1);
    check("b55_no_err", 32'(fe_cnt + ov_cnt), 32'd0);

    // False start: short low glitch.
    s_vrise = vrise; s_fe = fe_cnt; s_ov = ov_cnt;
    rx = 1'b0;
    wait_cycles(4);
    rx = 1'b1;
    wait_cycles(3 * Cpb);
    check("glitch_no_valid", 32'(vrise - s_vrise), 32'd0);
    check("glitch_no_err", 32'((fe_cnt - s_fe) + (ov_cnt - s_ov)), 32'd0);
    send_frame(8'hC3, 1'b1, e0);
    exp_q.push_back(8'hC3);
    rx = 1'b1;
    wait_cycles(4);
    check("glitch_next_data", 32'(acc_q[acc_q.size() - 1]), 32'hC3);

    // Bad stop bit followed by a long low line.
    s_vrise = vrise; s_fe = fe_cnt;
    send_frame(8'hA3, 1'b0, e0);
    wait_cycles(3 * Cpb);
    check("ferr_one_pulse", 32'(fe_cnt - s_fe), 32'd1);
    check("ferr_no_valid_low", 32'(vrise - s_vrise), 32'd0);
    rx = 1'b1;
    wait_cycles(12 * Cpb);
    check("ferr_no_frame_while_low", 32'(vrise - s_vrise), 32'd0);
    check("ferr_no_extra_pulse", 32'(fe_cnt - s_fe), 32'd1);
    send_frame(8'h3C, 1'b1, e0);
    exp_q.push_back(8'h3C);
    rx = 1'b1;
    wait_cycles(4);
    check("ferr_next_data", 32'(acc_q[acc_q.size() - 1]), 32'h3C);

    // Overrun: directed pair, then a random-length run, both with ready low.
    for (int run = 0; run < 2; run++) begin
      n = (run == 0) ? 2 : int'($urandom_range(2, 4));
      ready = 1'b0;
      s_ov  = ov_cnt;
      s_acc = acc_q.size();
      for (int k = 0; k < n; k++) begin
        b = (run == 0) ? ((k == 0) ? 8'h12 : 8'h34) : 8'($urandom);
        if (k == 0) first = b;
        send_frame(b, 1'b1, e0);
      end
      rx = 1'b1;
      wait_cycles(4);
      check("ovr_data_held", 32'(data), 32'(first));
      check("ovr_valid_held", 32'(valid), 32'h1);
      check("ovr_pulses", 32'(ov_cnt - s_ov), 32'(n - 1));
      check("ovr_no_accept", 32'(acc_q.size() - s_acc), 32'd0);
      ready = 1'b1;
      exp_q.push_back(first);
      @(negedge clk);
      #2;
      check("ovr_valid_clears", 32'(valid), 32'h0);
      wait_cycles(10);
    end

    // Back-to-back with ready high: directed then randomized with random gaps.
    b24[0] = 8'h00; b24[1] = 8'hFF; b24[2] = 8'h81;
    s_vrise = vrise; s_fe = fe_cnt; s_ov = ov_cnt;
    for (int k = 0; k < 3; k++) begin
      send_frame(b24[k], 1'b1, e0);
      exp_q.push_back(b24[k]);
    end
    rx = 1'b1;
    wait_cycles(4);
    check("b2b_three_valid", 32'(vrise - s_vrise), 32'd3);
    check("b2b_no_err", 32'((fe_cnt - s_fe) + (ov_cnt - s_ov)), 32'd0);
    for (int k = 0; k < 6; k++) begin
      rx = 1'b1;
      wait_cycles(int'($urandom_range(0, 30)));
      b = 8'($urandom);
      send_frame(b, 1'b1, e0);
      exp_q.push_back(b);
    end
    rx = 1'b1;
    wait_cycles(4);

    // Reset mid-frame while a byte is pending.
    ready = 1'b0;
    first = 8'($urandom_range(1, 255));
    send_frame(first, 1'b1, e0);
    check("rst_pre_valid", 32'(valid), 32'h1);
    check("rst_pre_data", 32'(data), 32'(first));
    b = 8'($urandom);
    rx = 1'b0;
    wait_cycles(Cpb);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      wait_cycles(Cpb);
    end
    rx = b[4];
    wait_cycles(Half);
    rst = 1'b1;
    rx  = 1'b1;
    #2;
    check("rst_mid_data", 32'(data), 32'h00);
    check("rst_mid_valid", 32'(valid), 32'h0);
    check("rst_mid_pulses", 32'({frame_err, overrun}), 32'h0);
    wait_cycles(3);
    rst   = 1'b0;
    ready = 1'b1;
    s_vrise = vrise; s_fe = fe_cnt; s_ov = ov_cnt;
    wait_cycles(12 * Cpb);
    check("rst_abort_no_valid", 32'(vrise - s_vrise), 32'd0);
    send_frame(8'hF0, 1'b1, e0);
    exp_q.push_back(8'hF0);
    rx = 1'b1;
    wait_cycles(4);
    check("rst_next_data", 32'(acc_q[acc_q.size() - 1]), 32'hF0);
    check("rst_abort_no_err", 32'((fe_cnt - s_fe) + (ov_cnt - s_ov)), 32'd0);

    // Whole-run bookkeeping.
    check("acc_count", 32'(acc_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
      check($sformatf("acc_byte_%0d", i), 32'(acc_q[i]), 32'(exp_q[i]));
    end
    check("pulse_never_both", 32'(both_cnt), 32'd0);
    check("ferr_width_one", 32'(fe_wide), 32'd0);
    check("ovr_width_one", 32'(ov_wide), 32'd0);
    check("data_stable", 32'(stab_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
